// File: rtl/assoc_wb_cache_if.sv
// Bundle of datapath-side and memory-side signals for one assoc_wb_cache channel.
// slave is the cache's view; master is the combined datapath + memory view.
interface assoc_wb_cache_if #(
  parameter int WORD_SIZE       = 16,
  parameter int WORDS_PER_BLOCK = 4
);
  localparam int BLK_W = WORD_SIZE * WORDS_PER_BLOCK;

  logic                 c_read;
  logic                 c_write;
  logic [WORD_SIZE-1:0] c_addr;
  logic [WORD_SIZE-1:0] c_wdata;
  logic [WORD_SIZE-1:0] c_rdata;
  logic                 c_ready;
  logic                 c_hit;
  logic                 m_read;
  logic                 m_write;
  logic [WORD_SIZE-1:0] m_addr;
  logic [BLK_W-1:0]     m_wdata;
  logic [BLK_W-1:0]     m_rdata;
  logic                 m_ack;

  modport master (
    output c_read, c_write, c_addr, c_wdata, m_rdata, m_ack,
    input  c_rdata, c_ready, c_hit, m_read, m_write, m_addr, m_wdata
  );

  modport slave (
    input  c_read, c_write, c_addr, c_wdata, m_rdata, m_ack,
    output c_rdata, c_ready, c_hit, m_read, m_write, m_addr, m_wdata
  );
endinterface

// File: rtl/assoc_wb_cache.sv
// Write-back, write-allocate 1/2-way set-associative cache with LRU and req/ack memory side.
// Optional hit/access counters enabled by defining CACHE_PERF_CNT_EN.
module assoc_wb_cache #(
  parameter int WORD_SIZE       = 16,
  parameter int NUM_SETS        = 4,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int ASSOC           = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  assoc_wb_cache_if.slave      bus
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [WORD_SIZE-1:0] access_cnt,
  output logic [WORD_SIZE-1:0] hit_cnt
`endif
);
  localparam int OFF_W = $clog2(WORDS_PER_BLOCK);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = WORD_SIZE - IDX_W - OFF_W;
  localparam int BLK_W = WORD_SIZE * WORDS_PER_BLOCK;

  typedef enum logic [1:0] {IDLE, WB, FILL, RESPOND} stateT;

  stateT                state;
  logic [TAG_W-1:0]     tagArr  [NUM_SETS][ASSOC];
  logic [BLK_W-1:0]     dataArr [NUM_SETS][ASSOC];
  logic [ASSOC-1:0]     valid   [NUM_SETS];
  logic [ASSOC-1:0]     dirty   [NUM_SETS];
  logic [NUM_SETS-1:0]  lru;

  logic                 victimWay;
  logic                 victimSel;
  logic                 hitWay;
  logic                 hit;
  logic                 mRead;
  logic                 mWrite;
  logic [WORD_SIZE-1:0] mAddr;
  logic [BLK_W-1:0]     mWdata;

  logic                 req;
  logic                 isWrite;
  logic [TAG_W-1:0]     addrTag;
  logic [IDX_W-1:0]     addrIdx;
  logic [OFF_W-1:0]     addrOff;
  logic [WORD_SIZE-1:0] fillAddr;

  assign req      = bus.c_read | bus.c_write;
  assign isWrite  = bus.c_write;
  assign addrTag  = bus.c_addr[WORD_SIZE-1 -: TAG_W];
  assign addrIdx  = bus.c_addr[OFF_W +: IDX_W];
  assign addrOff  = bus.c_addr[OFF_W-1:0];
  assign fillAddr = {addrTag, addrIdx, {OFF_W{1'b0}}};

  assign bus.m_read  = mRead;
  assign bus.m_write = mWrite;
  assign bus.m_addr  = mAddr;
  assign bus.m_wdata = mWdata;

  function automatic logic [WORD_SIZE-1:0] wordOf(input logic [BLK_W-1:0] line,
                                                  input logic [OFF_W-1:0] off);
    logic [WORD_SIZE-1:0] w;
    w = '0;
    for (int k = 0; k < WORDS_PER_BLOCK; k++)
      if (off == OFF_W'(k)) w = line[k*WORD_SIZE +: WORD_SIZE];
    return w;
  endfunction

  function automatic logic [BLK_W-1:0] mergeWord(input logic [BLK_W-1:0] line,
                                                 input logic [OFF_W-1:0] off,
                                                 input logic [WORD_SIZE-1:0] data);
    logic [BLK_W-1:0] l;
    l = line;
    for (int k = 0; k < WORDS_PER_BLOCK; k++)
      if (off == OFF_W'(k)) l[k*WORD_SIZE +: WORD_SIZE] = data;
    return l;
  endfunction

  // LRU points at the way to evict next, so a touch moves it to the other way.
  function automatic logic otherWay(input logic w);
    return (ASSOC == 2) ? ~w : 1'b0;
  endfunction

  always_comb begin
    hit    = 1'b0;
    hitWay = 1'b0;
    for (int w = 0; w < ASSOC; w++)
      if (valid[addrIdx][w] && tagArr[addrIdx][w] == addrTag) begin
        hit    = 1'b1;
        hitWay = 1'(w);
      end
  end

  // Lowest invalid way wins; otherwise fall back to the LRU way.
  always_comb begin
    victimSel = (ASSOC == 2) ? lru[addrIdx] : 1'b0;
    for (int w = ASSOC - 1; w >= 0; w--)
      if (!valid[addrIdx][w]) victimSel = 1'(w);
  end

  always_comb begin
    bus.c_ready = 1'b0;
    bus.c_hit   = 1'b1;
    bus.c_rdata = '0;
    case (state)
      IDLE: begin
        if (req) begin
          bus.c_hit   = hit;
          bus.c_ready = hit;
          if (hit && !isWrite) bus.c_rdata = wordOf(dataArr[addrIdx][hitWay], addrOff);
        end
      end
      WB, FILL: bus.c_hit = 1'b0;
      RESPOND: begin
        bus.c_ready = 1'b1;
        bus.c_hit   = 1'b0;
        if (!isWrite) bus.c_rdata = wordOf(dataArr[addrIdx][victimWay], addrOff);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      valid     <= '{default: '0};
      dirty     <= '{default: '0};
      lru       <= '0;
      victimWay <= 1'b0;
      mRead     <= 1'b0;
      mWrite    <= 1'b0;
      mAddr     <= '0;
      mWdata    <= '0;
`ifdef CACHE_PERF_CNT_EN
      access_cnt <= '0;
      hit_cnt    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
`ifdef CACHE_PERF_CNT_EN
            access_cnt <= access_cnt + WORD_SIZE'(1);
            if (hit) hit_cnt <= hit_cnt + WORD_SIZE'(1);
`endif
            if (hit) begin
              lru[addrIdx] <= otherWay(hitWay);
              if (isWrite) dirty[addrIdx][hitWay] <= 1'b1;
            end else begin
              victimWay <= victimSel;
              if (valid[addrIdx][victimSel] && dirty[addrIdx][victimSel]) begin
                state  <= WB;
                mWrite <= 1'b1;
                mAddr  <= {tagArr[addrIdx][victimSel], addrIdx, {OFF_W{1'b0}}};
                mWdata <= dataArr[addrIdx][victimSel];
              end else begin
                state <= FILL;
                mRead <= 1'b1;
                mAddr <= fillAddr;
              end
            end
          end
        end
        WB: begin
          if (bus.m_ack) begin
            dirty[addrIdx][victimWay] <= 1'b0;
            mWrite <= 1'b0;
            mWdata <= '0;
            mRead  <= 1'b1;
            mAddr  <= fillAddr;
            state  <= FILL;
          end
        end
        FILL: begin
          if (bus.m_ack) begin
            valid[addrIdx][victimWay] <= 1'b1;
            dirty[addrIdx][victimWay] <= 1'b0;
            mRead <= 1'b0;
            mAddr <= '0;
            state <= RESPOND;
          end
        end
        RESPOND: begin
          if (isWrite) dirty[addrIdx][victimWay] <= 1'b1;
          lru[addrIdx] <= otherWay(victimWay);
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line storage needs no reset; valid bits gate every use and reset forces IDLE.
  always_ff @(posedge clk) begin
    if (state == IDLE && req && hit && isWrite)
      dataArr[addrIdx][hitWay] <= mergeWord(dataArr[addrIdx][hitWay], addrOff, bus.c_wdata);
    if (state == FILL && bus.m_ack) begin
      dataArr[addrIdx][victimWay] <= bus.m_rdata;
      tagArr[addrIdx][victimWay]  <= addrTag;
    end
    if (state == RESPOND && isWrite)
      dataArr[addrIdx][victimWay] <= mergeWord(dataArr[addrIdx][victimWay], addrOff, bus.c_wdata);
  end
endmodule

// File: tb/tb_assoc_wb_cache.sv
// Directed self-checking bench for assoc_wb_cache (default parameters).
// Counter checks are compiled in when CACHE_PERF_CNT_EN is defined.
module tb_assoc_wb_cache;
  logic clk;
  logic reset_n;
  int   errors = 0;
  int   checks = 0;

  assoc_wb_cache_if #(.WORD_SIZE(16), .WORDS_PER_BLOCK(4)) bus ();

`ifdef CACHE_PERF_CNT_EN
  logic [15:0] accessCnt;
  logic [15:0] hitCnt;
`endif

  assoc_wb_cache #(
    .WORD_SIZE(16), .NUM_SETS(4), .WORDS_PER_BLOCK(4), .ASSOC(2)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
`ifdef CACHE_PERF_CNT_EN
    ,
    .access_cnt(accessCnt),
    .hit_cnt(hitCnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rd, input logic wr,
                               input logic [15:0] addr, input logic [15:0] wdata);
    bus.c_read  = rd;
    bus.c_write = wr;
    bus.c_addr  = addr;
    bus.c_wdata = wdata;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    bus.m_ack = 1'b0;
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0);
    tick();
    tick();
    reset_n = 1'b1;
    #1;
  endtask

  // Single-cycle hit: ready/hit/data observed combinationally, no memory traffic.
  task automatic doHit(input string tag, input logic wr, input logic [15:0] addr,
                       input logic [15:0] wdata, input logic [15:0] expRdata);
    applyStimulus(~wr, wr, addr, wdata);
    checkOutput({tag, ".ready"}, bus.c_ready, 1);
    checkOutput({tag, ".hit"}, bus.c_hit, 1);
    checkOutput({tag, ".rdata"}, bus.c_rdata, expRdata);
    checkOutput({tag, ".mtraffic"}, {bus.m_read, bus.m_write}, 0);
    tick();
    applyStimulus(1'b0, 1'b0, addr, 16'h0);
  endtask

  // Miss with optional write-back; memory acks after ackDelay extra cycles.
  task automatic doMiss(input string tag, input logic wr, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic expWb,
                        input logic [15:0] wbAddr, input logic [15:0] wbWord0,
                        input logic [63:0] fillBlk, input int ackDelay,
                        input logic [15:0] expRdata);
    applyStimulus(~wr, wr, addr, wdata);
    checkOutput({tag, ".missHit"}, bus.c_hit, 0);
    checkOutput({tag, ".missReady"}, bus.c_ready, 0);
    checkOutput({tag, ".idleMem"}, {bus.m_read, bus.m_write}, 0);
    tick();
    if (expWb) begin
      checkOutput({tag, ".wbWrite"}, {bus.m_write, bus.m_read}, 2'b10);
      checkOutput({tag, ".wbAddr"}, bus.m_addr, wbAddr);
      checkOutput({tag, ".wbData0"}, bus.m_wdata[15:0], wbWord0);
      repeat (ackDelay) tick();
      checkOutput({tag, ".wbHeld"}, bus.m_write, 1);
      bus.m_ack = 1'b1;
      tick();
      bus.m_ack = 1'b0;
    end
    checkOutput({tag, ".fillRead"}, {bus.m_read, bus.m_write}, 2'b10);
    checkOutput({tag, ".fillAddr"}, bus.m_addr, {addr[15:2], 2'b00});
    repeat (ackDelay) tick();
    checkOutput({tag, ".fillHeld"}, bus.m_read, 1);
    bus.m_ack   = 1'b1;
    bus.m_rdata = fillBlk;
    tick();
    bus.m_ack = 1'b0;
    checkOutput({tag, ".respReady"}, bus.c_ready, 1);
    checkOutput({tag, ".respHit"}, bus.c_hit, 0);
    checkOutput({tag, ".respMem"}, {bus.m_read, bus.m_write}, 0);
    checkOutput({tag, ".respRdata"}, bus.c_rdata, expRdata);
    tick();
    applyStimulus(1'b0, 1'b0, addr, 16'h0);
  endtask

  initial begin
    bus.c_read  = 1'b0;
    bus.c_write = 1'b0;
    bus.c_addr  = '0;
    bus.c_wdata = '0;
    bus.m_rdata = '0;
    bus.m_ack   = 1'b0;
    reset_n     = 1'b0;
    #3;
    checkOutput("rst.ready", bus.c_ready, 0);
    checkOutput("rst.hit", bus.c_hit, 1);
    checkOutput("rst.rdata", bus.c_rdata, 0);
    checkOutput("rst.mem", {bus.m_read, bus.m_write}, 0);
    checkOutput("rst.maddr", bus.m_addr, 0);
    checkOutput("rst.mwdata", bus.m_wdata, 0);
    doReset();

    // Cold miss, then read hit, write hit, read-back.
    doMiss("cold", 1'b0, 16'h0010, 16'h0, 1'b0, 16'h0, 16'h0,
           64'h4444_3333_2222_1111, 2, 16'h1111);
    doHit("hit11", 1'b0, 16'h0011, 16'h0, 16'h2222);
    doHit("wrHit", 1'b1, 16'h0012, 16'hBEEF, 16'h0000);
    doHit("rdBeef", 1'b0, 16'h0012, 16'h0, 16'hBEEF);
`ifdef CACHE_PERF_CNT_EN
    checkOutput("perf.access", accessCnt, 4);
    checkOutput("perf.hit", hitCnt, 3);
`endif

    // LRU with clean victims in set 0.
    doReset();
    doMiss("fillA", 1'b0, 16'h0000, 16'h0, 1'b0, 16'h0, 16'h0,
           64'h0A03_0A02_0A01_0A00, 0, 16'h0A00);
    doMiss("fillB", 1'b0, 16'h0100, 16'h0, 1'b0, 16'h0, 16'h0,
           64'h0B03_0B02_0B01_0B00, 0, 16'h0B00);
    doHit("touchA", 1'b0, 16'h0000, 16'h0, 16'h0A00);
    doMiss("fillC", 1'b0, 16'h0200, 16'h0, 1'b0, 16'h0, 16'h0,
           64'h0C03_0C02_0C01_0C00, 1, 16'h0C00);
    doHit("keepA", 1'b0, 16'h0000, 16'h0, 16'h0A00);
    doMiss("reB", 1'b0, 16'h0100, 16'h0, 1'b0, 16'h0, 16'h0,
           64'h0B03_0B02_0B01_0B00, 0, 16'h0B00);

    // Dirty eviction of the 0x0100 line.
    doHit("wrB", 1'b1, 16'h0100, 16'hAAAA, 16'h0000);
    doHit("touchA2", 1'b0, 16'h0000, 16'h0, 16'h0A00);
    doMiss("dirtyEvict", 1'b0, 16'h0300, 16'h0, 1'b1, 16'h0100, 16'hAAAA,
           64'h0D03_0D02_0D01_0D00, 2, 16'h0D00);
    doHit("afterEvictA", 1'b0, 16'h0000, 16'h0, 16'h0A00);
    doMiss("reloadB", 1'b0, 16'h0100, 16'h0, 1'b0, 16'h0, 16'h0,
           64'h0B03_0B02_0B01_AAAA, 0, 16'hAAAA);

    // Write-allocate miss in set 1.
    doMiss("wrMiss", 1'b1, 16'h0204, 16'h1234, 1'b0, 16'h0, 16'h0,
           64'h0E03_0E02_0E01_0E00, 1, 16'h0000);
    doHit("rdAlloc", 1'b0, 16'h0204, 16'h0, 16'h1234);
    doHit("rdAllocW1", 1'b0, 16'h0205, 16'h0, 16'h0E01);

    // Reset while FILL waits for ack.
    applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0);
    tick();
    checkOutput("midFill.mread", bus.m_read, 1);
    reset_n = 1'b0;
    #1;
    checkOutput("midRst.mread", bus.m_read, 0);
    checkOutput("midRst.maddr", bus.m_addr, 0);
    checkOutput("midRst.ready", bus.c_ready, 0);
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0);
    tick();
    reset_n = 1'b1;
    #1;
    doMiss("postRst", 1'b0, 16'h0010, 16'h0, 1'b0, 16'h0, 16'h0,
           64'h4444_3333_2222_1111, 0, 16'h1111);

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
